// File: rtl/fhe_ntt_sched_pkg.sv
// Shared types and default sizing for the NTT stage/butterfly scheduler.
package fhe_ntt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } NttSchedState;

  localparam int unsigned NTT_LOG_N  = 12;
  localparam int unsigned NTT_BF_LAT = 6;

endpackage

// File: rtl/fhe_ntt_sched_wb_dly.sv
// Fixed-depth valid+data shift line carrying issue addresses to write-back.
module fhe_ntt_wb_dly #(
  parameter int unsigned DEPTH = 6,
  parameter int unsigned W     = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vld_i,
  input  logic [W-1:0] data_i,
  output logic         vld_o,
  output logic [W-1:0] data_o
);

  logic [DEPTH-1:0] vld_q;
  logic [W-1:0]     dat_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= vld_i;
      dat_q[0] <= data_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign vld_o  = vld_q[DEPTH-1];
  assign data_o = dat_q[DEPTH-1];

endmodule

// File: rtl/fhe_ntt_sched.sv
// Radix-2 NTT/INTT scheduler: walks LOG_N stages of N/2 butterflies, issues
// operand addresses and twiddle indices, drains the pipe between stages.
module fhe_ntt_sched
  import fhe_ntt_sched_pkg::*;
#(
  parameter int unsigned LOG_N  = NTT_LOG_N,
  parameter int unsigned BF_LAT = NTT_BF_LAT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     inverse,
  output logic                     busy,
  output logic                     done,
  output logic                     bf_valid,
  input  logic                     bf_ready,
  output logic [LOG_N-1:0]         addr_a,
  output logic [LOG_N-1:0]         addr_b,
  output logic [LOG_N-2:0]         tw_idx,
  output logic                     tw_inv,
  output logic [$clog2(LOG_N)-1:0] stage,
  output logic                     wb_valid,
  output logic [LOG_N-1:0]         wb_addr_a,
  output logic [LOG_N-1:0]         wb_addr_b
);

  localparam int unsigned SW = $clog2(LOG_N);

  NttSchedState     state_q;
  logic [LOG_N-2:0] j_q;
  logic [SW-1:0]    s_q;
  logic             inv_q;
  logic [LOG_N-1:0] outst_q, outst_d;

  logic             issue_acc;
  logic             last_stage;
  logic [SW-1:0]    sh;
  logic [LOG_N-1:0] j_ext, m, k, g, a_raw;
  logic [LOG_N-2:0] tw_raw;
  logic [2*LOG_N-1:0] wb_data;

  // Butterfly address generation: span m = 2^(LOG_N-1-s), group g, offset k.
  always_comb begin
    sh     = SW'(LOG_N-1) - s_q;
    j_ext  = {1'b0, j_q};
    m      = LOG_N'(1) << sh;
    k      = j_ext & (m - LOG_N'(1));
    g      = j_ext >> sh;
    a_raw  = ((g << sh) << 1) | k;
    tw_raw = k[LOG_N-2:0] << s_q;
  end

  assign bf_valid  = (state_q == ISSUE);
  assign issue_acc = bf_valid & bf_ready;
  assign addr_a    = bf_valid ? a_raw : '0;
  assign addr_b    = bf_valid ? (a_raw | m) : '0;
  assign tw_idx    = bf_valid ? tw_raw : '0;
  assign tw_inv    = inv_q;
  assign stage     = s_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  assign last_stage = inv_q ? (s_q == '0) : (s_q == SW'(LOG_N-1));

  always_comb begin
    outst_d = outst_q + LOG_N'(issue_acc) - LOG_N'(wb_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      j_q     <= '0;
      s_q     <= '0;
      inv_q   <= 1'b0;
      outst_q <= '0;
    end else begin
      outst_q <= outst_d;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            inv_q   <= inverse;
            j_q     <= '0;
            s_q     <= inverse ? SW'(LOG_N-1) : '0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_acc) begin
            if (j_q == '1) begin
              j_q     <= '0;
              state_q <= DRAIN;
            end else begin
              j_q <= j_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          // RAW barrier: the next stage reads what this stage writes back.
          if (outst_q == '0) begin
            if (last_stage) begin
              state_q <= DONE;
            end else begin
              s_q     <= inv_q ? s_q - 1'b1 : s_q + 1'b1;
              state_q <= ISSUE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  fhe_ntt_wb_dly #(
    .DEPTH (BF_LAT),
    .W     (2*LOG_N)
  ) u_wb_dly (
    .clk    (clk),
    .rst    (rst),
    .vld_i  (issue_acc),
    .data_i ({addr_a, addr_b}),
    .vld_o  (wb_valid),
    .data_o (wb_data)
  );

  assign wb_addr_a = wb_data[2*LOG_N-1:LOG_N];
  assign wb_addr_b = wb_data[LOG_N-1:0];

endmodule

// File: tb/tb_fhe_ntt_sched.sv
// Randomized self-checking bench for fhe_ntt_sched against a formula-level model.
module tb_fhe_ntt_sched;

  localparam int LOG_N  = 4;
  localparam int BF_LAT = 3;
  localparam int HALF   = 1 << (LOG_N - 1);

  logic       clk;
  logic       rst;
  logic       start;
  logic       inverse;
  logic       busy;
  logic       done;
  logic       bf_valid;
  logic       bf_ready;
  logic [3:0] addr_a;
  logic [3:0] addr_b;
  logic [2:0] tw_idx;
  logic       tw_inv;
  logic [1:0] stage;
  logic       wb_valid;
  logic [3:0] wb_addr_a;
  logic [3:0] wb_addr_b;

  fhe_ntt_sched #(
    .LOG_N  (LOG_N),
    .BF_LAT (BF_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .inverse   (inverse),
    .busy      (busy),
    .done      (done),
    .bf_valid  (bf_valid),
    .bf_ready  (bf_ready),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .tw_idx    (tw_idx),
    .tw_inv    (tw_inv),
    .stage     (stage),
    .wb_valid  (wb_valid),
    .wb_addr_a (wb_addr_a),
    .wb_addr_b (wb_addr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    int b;
    int tw;
    int s;
    bit last;
  } iss_t;

  typedef struct {
    int a;
    int b;
    int due;
  } wb_t;

  iss_t exp_q[$];
  wb_t  wbq[$];
  int   cyc;
  int   n_vec;
  int   n_err;
  int   dcyc;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Expected issue order straight from the stage/butterfly definitions.
  task automatic build(input bit inv);
    exp_q.delete();
    for (int si = 0; si < LOG_N; si++) begin
      int s;
      int m;
      s = inv ? (LOG_N - 1 - si) : si;
      m = 1 << (LOG_N - 1 - s);
      for (int j = 0; j < HALF; j++) begin
        iss_t e;
        e.a    = (j / m) * 2 * m + (j % m);
        e.b    = e.a + m;
        e.tw   = (j % m) * (1 << s);
        e.s    = s;
        e.last = (j == HALF - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run_xfer(input bit inv, input int mode, input bit noise, input bit hold,
                          output int done_cyc);
    int   expect_rise;
    int   stalls;
    int   issues;
    int   wbs;
    int   last_acc;
    bit   prev_v;
    bit   seen_done;
    bit   r;
    bit   exp_wb;
    iss_t e;
    build(inv);
    wbq.delete();
    step();
    cyc      = 0;
    start    = 1'b1;
    inverse  = inv;
    bf_ready = 1'b1;
    check("idle_busy", busy, 0);
    check("idle_valid", bf_valid, 0);
    expect_rise = 1;
    stalls      = 0;
    issues      = 0;
    wbs         = 0;
    last_acc    = 0;
    prev_v      = 1'b0;
    seen_done   = 1'b0;
    done_cyc    = -1;
    while (!seen_done && cyc < 3000) begin
      step();
      start = hold ? 1'b1 : (noise ? ($urandom_range(0, 3) == 0) : 1'b0);
      if (noise) inverse = $urandom_range(0, 1);
      case (mode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 2) != 0);
        default: r = !(cyc >= 15 && cyc < 20);
      endcase
      bf_ready = r;
      check("busy", busy, 1);
      if (bf_valid && !prev_v) check("rise_cycle", cyc, expect_rise);
      prev_v = bf_valid;
      if (bf_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_issue", bf_valid, 0);
        end else begin
          e = exp_q[0];
          check("addr_a", addr_a, e.a);
          check("addr_b", addr_b, e.b);
          check("tw_idx", tw_idx, e.tw);
          check("stage", stage, e.s);
          check("tw_inv", tw_inv, inv);
          if (r) begin
            void'(exp_q.pop_front());
            wbq.push_back('{e.a, e.b, cyc + BF_LAT});
            issues++;
            last_acc = cyc;
            if (e.last) expect_rise = cyc + BF_LAT + 2;
          end else begin
            stalls++;
          end
        end
      end
      exp_wb = (wbq.size() > 0) && (wbq[0].due == cyc);
      check("wb_valid", wb_valid, exp_wb);
      if (exp_wb) begin
        check("wb_addr_a", wb_addr_a, wbq[0].a);
        check("wb_addr_b", wb_addr_b, wbq[0].b);
        void'(wbq.pop_front());
        wbs++;
      end
      if (done) begin
        seen_done = 1'b1;
        done_cyc  = cyc;
      end
    end
    start = 1'b0;
    check("done_seen", seen_done, 1);
    check("done_cycle", done_cyc, 1 + LOG_N * (HALF + BF_LAT + 1) + stalls);
    check("done_after_drain", done_cyc, last_acc + BF_LAT + 2);
    check("issue_count", issues, LOG_N * HALF);
    check("wb_count", wbs, LOG_N * HALF);
    if (mode == 2) check("stall_cycles", stalls, 5);
  endtask

  task automatic after_done();
    step();
    check("done_pulse", done, 0);
    check("back_idle", busy, 0);
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    cyc      = 0;
    rst      = 1'b1;
    start    = 1'b0;
    inverse  = 1'b0;
    bf_ready = 1'b0;
    step();
    step();
    check("reset_outputs",
          {busy, done, bf_valid, addr_a, addr_b, tw_idx, tw_inv, stage,
           wb_valid, wb_addr_a, wb_addr_b}, 0);
    rst = 1'b0;

    run_xfer(1'b0, 0, 1'b0, 1'b0, dcyc);
    check("fwd_done_49", dcyc, 49);
    after_done();
    run_xfer(1'b1, 0, 1'b0, 1'b0, dcyc);
    after_done();
    run_xfer(1'b0, 2, 1'b0, 1'b0, dcyc);
    check("stall_done_54", dcyc, 54);
    after_done();
    for (int t = 0; t < 4; t++) begin
      run_xfer(t[0], 1, 1'b1, 1'b0, dcyc);
      after_done();
    end

    // start held through DONE relaunches from IDLE
    run_xfer(1'b0, 0, 1'b0, 1'b1, dcyc);
    start = 1'b1;
    step();
    check("hold_idle", busy, 0);
    step();
    check("hold_restart_valid", bf_valid, 1);
    check("hold_restart_b", addr_b, HALF);
    start = 1'b0;

    // abort mid-stage1 with reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    start   = 1'b1;
    inverse = 1'b0;
    bf_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 16; i++) step();
    check("abort_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_outputs",
          {busy, done, bf_valid, addr_a, addr_b, tw_idx, tw_inv, stage,
           wb_valid, wb_addr_a, wb_addr_b}, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("abort_quiet", {busy, done, bf_valid, wb_valid}, 0);
    end

    run_xfer(1'b0, 0, 1'b0, 1'b0, dcyc);
    check("fresh_done_49", dcyc, 49);
    after_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
